trigger_source: RTL and testbench
=================================

# trigger_source

Trigger qualifier sitting directly upstream of the trigger-delay stage: it selects one trigger source (external pin, internal periodic timer, or software strobe), conditions it, and emits a clean, fixed-width, synchronous trigger pulse. The block enforces arming, burst counting and a hold-off window, so the downstream delay stage only ever sees well-spaced rising edges.

## Interface
- SYNC_STAGES, 2: synchroniser depth on ipExtTrigger; legal range 2-4.
- ipClk  in  1  system clock; all logic on its rising edge.
- ipReset  in  1  synchronous, active-low reset (0 = reset), sampled on ipClk.
- ipEnable  in  1  master enable. Low forces IDLE.
- ipMode  in  2  source select: 0 = none, 1 = external, 2 = internal periodic, 3 = software. Latched on arm.
- ipArm  in  1  single-cycle arm strobe.
- ipBurst  in  16  triggers per arm; 0 = continuous. Latched on arm.
- ipPeriod  in  32  internal period in cycles; 0 = no internal events. Latched on arm.
- ipWidth  in  16  output pulse width in cycles; 0 treated as 1.
- ipHoldoff  in  32  dead time after each pulse in cycles.
- ipExtTrigger  in  1  asynchronous external trigger, rising-edge active.
- ipSoftTrigger  in  1  synchronous software strobe, level-high per cycle.
- opTrigger  out  1  qualified trigger pulse to the delay stage.
- opArmed  out  1  high in ARMED state.
- opBusy  out  1  high in PULSE or HOLDOFF.
- opDone  out  1  one-cycle pulse when a finite burst completes.
- opCount  out  32  total pulses issued since reset; wraps modulo 2^32.
- opMissed  out  16  events dropped while not ARMED; saturates at 0xFFFF.

## Operation
- States: IDLE, ARMED, PULSE, HOLDOFF. Reset: IDLE; all outputs 0; counters 0.
- IDLE -> ARMED on ipArm while ipEnable=1. Latches mode/burst/period; burst-remaining <= ipBurst; period counter <= ipPeriod. ipArm outside IDLE is ignored.
- Event sources, per latched mode:
  - External: ipExtTrigger through SYNC_STAGES flops, then rising-edge detect on the last stage.
  - Software: ipSoftTrigger high.
  - Internal: period counter decrements every cycle while not IDLE. At value 1 it generates an event and reloads ipPeriod (latched). It is free-running, so the cadence is independent of pulse/hold-off.
- ARMED + event -> PULSE: opTrigger=1, width counter <= max(ipWidth,1), opCount++, burst-remaining-- (if finite).
- PULSE: opTrigger held high for exactly the width. Then -> HOLDOFF if ipHoldoff>0, else straight to the exit decision.
- HOLDOFF: lasts ipHoldoff cycles. Exit decision: finite burst with remaining = 0 -> IDLE with opDone pulse; otherwise -> ARMED.
- Events arriving in PULSE or HOLDOFF are dropped and increment opMissed. Events in IDLE are ignored and not counted.
- ipEnable=0 in any state: next cycle IDLE, opTrigger=0, no opDone; opCount and opMissed are retained.
- Reset mid-pulse: opTrigger low at the next edge; all state cleared.

## Timing
- Software: ipSoftTrigger high before edge k -> opTrigger high after edge k (1-cycle latency).
- External: ipExtTrigger rising and stable before edge k -> opTrigger high after edge k+SYNC_STAGES.
- Internal: first pulse ipPeriod cycles after arm. Subsequent pulses every ipPeriod cycles exactly when max(ipWidth,1)+ipHoldoff < ipPeriod; otherwise the colliding events are dropped and counted.
- opTrigger is a registered output; minimum low time between pulses is ipHoldoff+1 cycles when holdoff>0 (≥1 cycle in all cases via the ARMED state).
- opDone is coincident with the IDLE entry cycle.
- opArmed and opBusy are registered and decoded from the state register.

## Test plan
- Reset: hold ipReset=0 for 3 cycles with ipExtTrigger toggling -> all outputs 0, state IDLE; release -> still no pulses until arm.
- Software single: mode 3, burst 1, width 4, holdoff 0, arm, soft strobe -> one 4-cycle pulse starting 1 cycle later, opDone on the following cycle, opCount=1.
- Internal periodic: mode 2, period 10, width 2, holdoff 3, burst 0 -> pulses every 10 cycles, first 10 cycles after arm; opMissed=0 after 100 cycles.
- External with collisions: mode 1, width 5, holdoff 10, edges 8 cycles apart -> every second edge dropped, opMissed increments; latency SYNC_STAGES cycles.
- Burst of 3, continuous soft strobe, holdoff 2 -> exactly 3 pulses, then IDLE with opDone; further ipArm re-arms.
- Abort: drop ipEnable mid-pulse -> opTrigger low at the next edge, IDLE, no opDone; opCount unchanged.

Source files
------------

// File: rtl/trigger_source.sv
// Trigger qualifier: selects an external, periodic or software trigger source,
// applies arming, burst counting and hold-off, and emits a fixed-width pulse.
module trigger_source #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic        ipEnable,
  input  logic [1:0]  ipMode,
  input  logic        ipArm,
  input  logic [15:0] ipBurst,
  input  logic [31:0] ipPeriod,
  input  logic [15:0] ipWidth,
  input  logic [31:0] ipHoldoff,
  input  logic        ipExtTrigger,
  input  logic        ipSoftTrigger,
  output logic        opTrigger,
  output logic        opArmed,
  output logic        opBusy,
  output logic        opDone,
  output logic [31:0] opCount,
  output logic [15:0] opMissed
);

  localparam int unsigned BURST_W  = 16;
  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned WIDTH_W  = 16;
  localparam int unsigned HOLD_W   = 32;
  localparam int unsigned COUNT_W  = 32;
  localparam int unsigned MISSED_W = 16;

  localparam logic [1:0] MODE_EXT  = 2'd1;
  localparam logic [1:0] MODE_INT  = 2'd2;
  localparam logic [1:0] MODE_SOFT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } stateT;

  stateT                state;
  logic [1:0]           modeLat;
  logic [BURST_W-1:0]   burstLat;
  logic [BURST_W-1:0]   burstRem;
  logic [PERIOD_W-1:0]  periodLat;
  logic [PERIOD_W-1:0]  periodCnt;
  logic [WIDTH_W-1:0]   widthCnt;
  logic [HOLD_W-1:0]    holdCnt;
  logic [SYNC_STAGES-1:0] extSync;
  logic                 extPrev;
  logic                 extRise;
  logic                 srcEvent;
  logic                 burstDone;
  logic                 busyDrop;
  logic [WIDTH_W-1:0]   widthLoad;

  // Synchronise the asynchronous external trigger and remember the last stage for edge detect
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      extSync <= '0;
      extPrev <= 1'b0;
    end else begin
      extSync <= {extSync[SYNC_STAGES-2:0], ipExtTrigger};
      extPrev <= extSync[SYNC_STAGES-1];
    end
  end

  assign extRise = extSync[SYNC_STAGES-1] & ~extPrev;

  // Free-running period counter: loaded on arm, reloads itself at 1 while not idle
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      periodCnt <= '0;
    end else if (state == IDLE) begin
      if (ipEnable && ipArm) begin
        periodCnt <= ipPeriod;
      end
    end else if (periodCnt == PERIOD_W'(1)) begin
      periodCnt <= periodLat;
    end else if (periodCnt != '0) begin
      periodCnt <= periodCnt - PERIOD_W'(1);
    end
  end

  // Event mux on the mode latched at arm time
  always_comb begin
    srcEvent = 1'b0;
    case (modeLat)
      MODE_EXT:  srcEvent = extRise;
      MODE_INT:  srcEvent = (periodCnt == PERIOD_W'(1));
      MODE_SOFT: srcEvent = ipSoftTrigger;
      default:   srcEvent = 1'b0;
    endcase
  end

  assign widthLoad = (ipWidth == '0) ? WIDTH_W'(1) : ipWidth;
  assign burstDone = (burstLat != '0) && (burstRem == '0);
  assign busyDrop  = ipEnable && srcEvent && ((state == PULSE) || (state == HOLDOFF));

  // Qualifier FSM with pulse/hold-off timers and statistics counters
  always_ff @(posedge ipClk) begin
    if (!ipReset) begin
      state     <= IDLE;
      modeLat   <= '0;
      burstLat  <= '0;
      burstRem  <= '0;
      periodLat <= '0;
      widthCnt  <= '0;
      holdCnt   <= '0;
      opTrigger <= 1'b0;
      opDone    <= 1'b0;
      opCount   <= '0;
      opMissed  <= '0;
    end else begin
      opDone <= 1'b0;
      if (busyDrop && (opMissed != {MISSED_W{1'b1}})) begin
        opMissed <= opMissed + MISSED_W'(1);
      end
      if (!ipEnable) begin
        state     <= IDLE;
        opTrigger <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ipArm) begin
              state     <= ARMED;
              modeLat   <= ipMode;
              burstLat  <= ipBurst;
              burstRem  <= ipBurst;
              periodLat <= ipPeriod;
            end
          end
          ARMED: begin
            if (srcEvent) begin
              state     <= PULSE;
              opTrigger <= 1'b1;
              widthCnt  <= widthLoad;
              opCount   <= opCount + COUNT_W'(1);
              if (burstLat != '0) begin
                burstRem <= burstRem - BURST_W'(1);
              end
            end
          end
          PULSE: begin
            if (widthCnt <= WIDTH_W'(1)) begin
              opTrigger <= 1'b0;
              if (ipHoldoff != '0) begin
                state   <= HOLDOFF;
                holdCnt <= ipHoldoff;
              end else if (burstDone) begin
                state  <= IDLE;
                opDone <= 1'b1;
              end else begin
                state <= ARMED;
              end
            end else begin
              widthCnt <= widthCnt - WIDTH_W'(1);
            end
          end
          HOLDOFF: begin
            if (holdCnt <= HOLD_W'(1)) begin
              if (burstDone) begin
                state  <= IDLE;
                opDone <= 1'b1;
              end else begin
                state <= ARMED;
              end
            end else begin
              holdCnt <= holdCnt - HOLD_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Status flags decoded from the state register
  assign opArmed = (state == ARMED);
  assign opBusy  = (state == PULSE) || (state == HOLDOFF);

endmodule

// File: tb/tb_trigger_source.sv
// Scoreboard bench for trigger_source: a timeline model predicts pulses,
// done strobes and counters; a monitor compares what the DUT emits.
module tb_trigger_source;

  localparam int SYNC = 2;

  logic        ipClk = 1'b0;
  logic        ipReset, ipEnable, ipArm, ipExtTrigger, ipSoftTrigger;
  logic [1:0]  ipMode;
  logic [15:0] ipBurst, ipWidth;
  logic [31:0] ipPeriod, ipHoldoff;
  logic        opTrigger, opArmed, opBusy, opDone;
  logic [31:0] opCount;
  logic [15:0] opMissed;

  trigger_source #(.SYNC_STAGES(SYNC)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable), .ipMode(ipMode),
    .ipArm(ipArm), .ipBurst(ipBurst), .ipPeriod(ipPeriod), .ipWidth(ipWidth),
    .ipHoldoff(ipHoldoff), .ipExtTrigger(ipExtTrigger), .ipSoftTrigger(ipSoftTrigger),
    .opTrigger(opTrigger), .opArmed(opArmed), .opBusy(opBusy), .opDone(opDone),
    .opCount(opCount), .opMissed(opMissed)
  );

  always #5 ipClk = ~ipClk;

  int cyc = 0;
  always @(posedge ipClk) cyc <= cyc + 1;

  int assertCount = 0;
  int failCount   = 0;

  function automatic void check(string nm, longint act, longint exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model (timeline arithmetic) ----------------
  typedef struct { int start; int width; } pulseT;
  pulseT expQ[$];
  int    doneQ[$];
  bit    extLvl[int];

  bit     mActive, mFinishing, mFinite;
  int     mArm, mReady, mIdleAfter, mRem, mMode, mPeriod, mLastStart, mLastW;
  longint mCount, mMissed;

  function automatic bit modelEvent(int e);
    int x;
    case (mMode)
      1: begin
        x = e - SYNC;
        return (extLvl.exists(x) && extLvl[x]) && !(extLvl.exists(x - 1) && extLvl[x - 1]);
      end
      2: return (mPeriod != 0) && (e > mArm) && (((e - mArm) % mPeriod) == 0);
      3: return ipSoftTrigger;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelEdge(int e);
    int w, h, endE;
    extLvl[e] = ipReset ? ipExtTrigger : 1'b0;
    if (!ipReset) begin
      mActive = 0; mCount = 0; mMissed = 0;
      return;
    end
    if (mActive && mFinishing && e > mIdleAfter) mActive = 0;
    if (!ipEnable) begin
      if (mActive) begin
        if (e < mLastStart + mLastW && expQ.size() > 0) expQ[$].width = e - mLastStart;
        if (mFinishing && doneQ.size() > 0 && doneQ[$] >= e) void'(doneQ.pop_back());
      end
      mActive = 0;
      return;
    end
    if (!mActive) begin
      if (ipArm) begin
        mActive = 1; mFinishing = 0; mArm = e; mReady = e + 1;
        mMode = int'(ipMode); mPeriod = int'(ipPeriod);
        mFinite = (ipBurst != 0); mRem = int'(ipBurst); mLastStart = -1000; mLastW = 0;
      end
      return;
    end
    if (!modelEvent(e)) return;
    if (e >= mReady) begin
      w = (ipWidth == 0) ? 1 : int'(ipWidth);
      h = int'(ipHoldoff);
      expQ.push_back('{start: e, width: w});
      mCount++; mLastStart = e; mLastW = w;
      if (mFinite) mRem--;
      endE = e + w + h;
      if (mFinite && mRem == 0) begin
        mFinishing = 1; mIdleAfter = endE; mReady = 32'h7fff_ffff;
        doneQ.push_back(endE);
      end else begin
        mReady = endE + 1;
      end
    end else if (mMissed < 65535) begin
      mMissed++;
    end
  endtask

  // ---------------- monitor ----------------
  bit prevTrig = 0;
  int curStart = 0;
  pulseT got;

  always @(negedge ipClk) begin
    if (opTrigger === 1'b1 && !prevTrig) curStart = cyc;
    if (opTrigger === 1'b0 && prevTrig) begin
      if (expQ.size() == 0) begin
        assertCount++; failCount++;
        $display("FAIL unexpected_pulse: start %0d width %0d, none expected", curStart, cyc - curStart);
      end else begin
        got = expQ.pop_front();
        check("pulse_start", curStart, got.start);
        check("pulse_width", cyc - curStart, got.width);
      end
    end
    prevTrig = (opTrigger === 1'b1);
    if (opDone === 1'b1) begin
      if (doneQ.size() == 0) begin
        assertCount++; failCount++;
        $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
      end else begin
        check("done_cycle", cyc, doneQ.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    modelEdge(cyc + 1);
    @(negedge ipClk);
  endtask

  task automatic arm();
    ipArm = 1'b1; step(); ipArm = 1'b0;
  endtask

  task automatic disableBlock();
    ipSoftTrigger = 1'b0; ipExtTrigger = 1'b0; ipArm = 1'b0;
    ipEnable = 1'b0; step(); step(); ipEnable = 1'b1;
  endtask

  task automatic checkCounters(string tag);
    check({tag, "_count"}, longint'(opCount), mCount);
    check({tag, "_missed"}, longint'(opMissed), mMissed);
  endtask

  longint savedMissed;

  initial begin
    ipReset = 1'b0; ipEnable = 1'b0; ipMode = 2'd0; ipArm = 1'b0;
    ipBurst = '0; ipPeriod = '0; ipWidth = 16'd1; ipHoldoff = '0;
    ipExtTrigger = 1'b0; ipSoftTrigger = 1'b0;
    mActive = 0; mCount = 0; mMissed = 0;
    @(negedge ipClk);

    // Reset held with the external pin toggling
    for (int i = 0; i < 3; i++) begin
      ipExtTrigger = ~ipExtTrigger;
      step();
      check("rst_trigger", opTrigger, 0);
      check("rst_armed", opArmed, 0);
      check("rst_count", opCount, 0);
    end
    check("rst_busy", opBusy, 0);
    check("rst_done", opDone, 0);
    check("rst_missed", opMissed, 0);
    ipReset = 1'b1; ipExtTrigger = 1'b0; ipEnable = 1'b1; ipMode = 2'd1;
    repeat (10) step();
    check("post_rst_armed", opArmed, 0);
    checkCounters("post_rst");

    // Software single shot, width 4, no hold-off
    ipMode = 2'd3; ipBurst = 16'd1; ipWidth = 16'd4; ipHoldoff = '0;
    arm();
    check("sw_armed", opArmed, 1);
    check("sw_busy_armed", opBusy, 0);
    step(); step();
    ipSoftTrigger = 1'b1; step(); ipSoftTrigger = 1'b0;
    check("sw_latency", opTrigger, 1);
    check("sw_busy", opBusy, 1);
    repeat (8) step();
    check("sw_idle_after_done", opArmed, 0);
    check("sw_count_one", opCount, 1);
    checkCounters("sw");

    // Internal periodic, period 10, width 2, hold-off 3, continuous
    ipMode = 2'd2; ipPeriod = 32'd10; ipWidth = 16'd2; ipHoldoff = 32'd3; ipBurst = '0;
    savedMissed = longint'(opMissed);
    arm();
    repeat (100) step();
    check("int_no_missed", opMissed, savedMissed);
    checkCounters("int");
    disableBlock();

    // External edges 8 cycles apart against a 15-cycle busy window
    ipMode = 2'd1; ipWidth = 16'd5; ipHoldoff = 32'd10; ipBurst = '0;
    arm();
    for (int k = 0; k < 12; k++) begin
      ipExtTrigger = 1'b1; repeat (4) step();
      ipExtTrigger = 1'b0; repeat (4) step();
    end
    repeat (20) step();
    checkCounters("ext");
    disableBlock();

    // Burst of 3 on a continuous strobe, width 0 treated as 1, then re-arm
    ipMode = 2'd3; ipBurst = 16'd3; ipHoldoff = 32'd2; ipWidth = 16'd0;
    ipSoftTrigger = 1'b1;
    arm();
    repeat (30) step();
    check("burst_idle", opArmed, 0);
    checkCounters("burst1");
    ipWidth = 16'd3;
    arm();
    repeat (30) step();
    checkCounters("burst2");
    disableBlock();

    // Abort by dropping enable mid-pulse
    ipMode = 2'd3; ipBurst = '0; ipWidth = 16'd8; ipHoldoff = '0;
    arm();
    ipSoftTrigger = 1'b1; step(); ipSoftTrigger = 1'b0;
    repeat (3) step();
    ipEnable = 1'b0; step();
    check("abort_trigger", opTrigger, 0);
    check("abort_armed", opArmed, 0);
    check("abort_busy", opBusy, 0);
    ipEnable = 1'b1; step();
    checkCounters("abort");

    // Randomised configurations and stimulus
    for (int it = 0; it < 10; it++) begin
      ipMode    = 2'($urandom_range(0, 3));
      ipBurst   = 16'($urandom_range(0, 4));
      ipWidth   = 16'($urandom_range(0, 6));
      ipHoldoff = 32'($urandom_range(0, 6));
      ipPeriod  = 32'($urandom_range(0, 12));
      arm();
      for (int c = 0; c < 150; c++) begin
        ipSoftTrigger = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 99) < 25) ipExtTrigger = ~ipExtTrigger;
        ipArm    = ($urandom_range(0, 99) < 3);
        ipEnable = ($urandom_range(0, 199) != 0);
        step();
      end
      disableBlock();
      checkCounters("rand");
    end

    repeat (3) step();
    check("pending_pulses", expQ.size(), 0);
    check("pending_done", doneQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
